// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: round-robin grant, one op in flight, result held until consumed.
// Accept at edge N, result registered at N+1, response valid from N+2; requesters stalled (ready low) until the response handshake.
module alu_arbiter #(
  parameter int unsigned FIRST_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  output logic        rsp0_err,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,
  output logic        rsp1_err,
  input  logic        rsp1_ready,
  output logic [31:0] alu_srca,
  output logic [31:0] alu_srcb,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        busy
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  // Last-grant reset value is the opposite of FIRST_PRIO so FIRST_PRIO wins the first tie.
  localparam logic RST_LAST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } opnd_t;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        err;
  } rsp_t;

  state_t r_state;
  state_t w_next_state;
  opnd_t  r_opnd;
  rsp_t   r_rsp;
  logic   r_gid;
  logic   r_last;

  logic   w_pick0;
  logic   w_pick1;
  logic   w_accept;
  logic   w_rsp_hs;
  logic   w_op_ok;
  logic   w_in_resp;
  opnd_t  w_req0;
  opnd_t  w_req1;

  assign w_req0 = '{a: req0_a, b: req0_b, op: req0_op};
  assign w_req1 = '{a: req1_a, b: req1_b, op: req1_op};

  // A tie goes to whichever requester was not granted last.
  assign w_pick0  = req0_valid && (!req1_valid || r_last);
  assign w_pick1  = req1_valid && (!req0_valid || !r_last);
  assign w_accept = (r_state == S_IDLE) && (w_pick0 || w_pick1);
  assign w_rsp_hs = r_gid ? rsp1_ready : rsp0_ready;

  always_comb begin
    w_op_ok = 1'b0;
    case (r_opnd.op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_NOR, OP_XOR, OP_SLT: w_op_ok = 1'b1;
      default:                w_op_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req0_ready = w_pick0 && !reset;
        req1_ready = w_pick1 && !reset;
        if (w_pick0 || w_pick1) begin
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        w_next_state = S_RESP;
      end
      S_RESP: begin
        if (w_rsp_hs) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_opnd  <= '{a: 32'd0, b: 32'd0, op: OP_ADD};
      r_rsp   <= '0;
      r_gid   <= 1'b0;
      r_last  <= RST_LAST;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_opnd <= w_pick1 ? w_req1 : w_req0;
        r_gid  <= w_pick1;
        r_last <= w_pick1;
      end
      // Unsupported ops never expose the ALU output.
      if (r_state == S_EXEC) begin
        if (w_op_ok) begin
          r_rsp <= '{result: alu_result, zero: alu_zero, err: 1'b0};
        end else begin
          r_rsp <= '{result: 32'd0, zero: 1'b0, err: 1'b1};
        end
      end
    end
  end

  assign alu_srca = r_opnd.a;
  assign alu_srcb = r_opnd.b;
  assign alu_op   = r_opnd.op;
  assign busy     = (r_state != S_IDLE);

  assign w_in_resp   = (r_state == S_RESP);
  assign rsp0_valid  = w_in_resp && !r_gid;
  assign rsp1_valid  = w_in_resp && r_gid;
  assign rsp0_result = rsp0_valid ? r_rsp.result : 32'd0;
  assign rsp0_zero   = rsp0_valid && r_rsp.zero;
  assign rsp0_err    = rsp0_valid && r_rsp.err;
  assign rsp1_result = rsp1_valid ? r_rsp.result : 32'd0;
  assign rsp1_zero   = rsp1_valid && r_rsp.zero;
  assign rsp1_err    = rsp1_valid && r_rsp.err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized transactions against alu_arbiter with a transaction-level reference model and a stub ALU.
module tb_alu_arbiter;

  localparam int unsigned FIRST_PRIO = 0;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] alu_srca, alu_srcb, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero;
  logic        alu_known;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int m_last = 1;

  alu_arbiter #(.FIRST_PRIO(FIRST_PRIO)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
    .rsp1_ready(rsp1_ready),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub ALU: garbage with zero=1 on unknown codes, so the arbiter must mask them.
  always_comb begin
    alu_known  = 1'b1;
    alu_result = 32'hDEAD_BEEF;
    case (alu_op)
      4'b0010: alu_result = alu_srca + alu_srcb;
      4'b0110: alu_result = alu_srca - alu_srcb;
      4'b0000: alu_result = alu_srca & alu_srcb;
      4'b0001: alu_result = alu_srca | alu_srcb;
      4'b1100: alu_result = ~(alu_srca | alu_srcb);
      4'b0011: alu_result = alu_srca ^ alu_srcb;
      4'b0111: alu_result = {31'd0, $signed(alu_srca) < $signed(alu_srcb)};
      default: alu_known = 1'b0;
    endcase
    alu_zero = alu_known ? (alu_result == 32'd0) : 1'b1;
  end

  // Expected response {err, zero, result} for one operation.
  function automatic logic [33:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [31:0] r;
    logic        e;
    e = 1'b0;
    r = 32'd0;
    if (op == 4'b0010)      r = a + b;
    else if (op == 4'b0110) r = a - b;
    else if (op == 4'b0000) r = a & b;
    else if (op == 4'b0001) r = a | b;
    else if (op == 4'b1100) r = ~(a | b);
    else if (op == 4'b0011) r = a ^ b;
    else if (op == 4'b0111) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    else                    e = 1'b1;
    return {e, (!e && r == 32'd0), r};
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set_req_valid(input int id, input logic v);
    if (id == 0) req0_valid = v;
    else         req1_valid = v;
  endtask

  task automatic set_rsp_ready(input int id, input logic v);
    if (id == 0) rsp0_ready = v;
    else         rsp1_ready = v;
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 32'hFFFF_0001; req0_b = 32'h7; req0_op = 4'b0110;
    req1_valid = 1'b1; req1_a = 32'h55;        req1_b = 32'h9; req1_op = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge clk);
    chk1({tag, ".busy"}, busy, 1'b0);
    chk1({tag, ".vld0"}, rsp0_valid, 1'b0);
    chk1({tag, ".vld1"}, rsp1_valid, 1'b0);
    chk1({tag, ".rdy0"}, req0_ready, 1'b0);
    chk32({tag, ".res0"}, rsp0_result, 32'd0);
    chk32({tag, ".res1"}, rsp1_result, 32'd0);
    chk32({tag, ".srca"}, alu_srca, 32'd0);
    chk32({tag, ".srcb"}, alu_srcb, 32'd0);
    chk32({tag, ".aluop"}, {28'd0, alu_op}, 32'h2);
    m_last = (FIRST_PRIO == 0) ? 1 : 0;
  endtask

  // One full transaction; force_g >= 0 overrides the model's grant choice with a literal expectation.
  // pester: 0 none, 1 loser valid through EXEC/RESP, 2 loser valid for one RESP cycle only.
  task automatic run_txn(input string tag, input bit v0, input bit v1,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] o0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] o1,
                         input int dly, input int pester, input int force_g);
    int          g, o;
    logic [31:0] ea, eb;
    logic [3:0]  eo;
    logic [33:0] ex;
    g = (v0 && v1) ? 1 - m_last : (v0 ? 0 : 1);
    if (force_g >= 0) g = force_g;
    o = 1 - g;
    m_last = g;
    ea = (g != 0) ? a1 : a0;
    eb = (g != 0) ? b1 : b0;
    eo = (g != 0) ? o1 : o0;
    ex = ref_op(ea, eb, eo);

    @(posedge clk); #1;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
    @(negedge clk);
    chk1({tag, ".idle.rdy0"}, req0_ready, g == 0);
    chk1({tag, ".idle.rdy1"}, req1_ready, g == 1);
    chk1({tag, ".idle.busy"}, busy, 1'b0);

    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = $urandom; req0_b = $urandom; req0_op = 4'($urandom_range(0, 15));
    req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom_range(0, 15));
    if (pester == 1) set_req_valid(o, 1'b1);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk);
    chk1({tag, ".exec.busy"}, busy, 1'b1);
    chk1({tag, ".exec.rdy0"}, req0_ready, 1'b0);
    chk1({tag, ".exec.rdy1"}, req1_ready, 1'b0);
    chk1({tag, ".exec.vld0"}, rsp0_valid, 1'b0);
    chk1({tag, ".exec.vld1"}, rsp1_valid, 1'b0);
    chk32({tag, ".exec.srca"}, alu_srca, ea);
    chk32({tag, ".exec.srcb"}, alu_srcb, eb);
    chk32({tag, ".exec.op"}, {28'd0, alu_op}, {28'd0, eo});

    @(posedge clk); #1;
    if (pester == 2) set_req_valid(o, 1'b1);
    for (int k = 0; k <= dly; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (pester == 2) set_req_valid(o, 1'b0);
      end
      set_rsp_ready(g, k == dly);
      set_rsp_ready(o, 1'($urandom_range(0, 1)));
      @(negedge clk);
      chk1({tag, ".resp.busy"}, busy, 1'b1);
      chk1({tag, ".resp.vldG"}, (g == 0) ? rsp0_valid : rsp1_valid, 1'b1);
      chk1({tag, ".resp.vldO"}, (o == 0) ? rsp0_valid : rsp1_valid, 1'b0);
      chk32({tag, ".resp.result"}, (g == 0) ? rsp0_result : rsp1_result, ex[31:0]);
      chk1({tag, ".resp.zero"}, (g == 0) ? rsp0_zero : rsp1_zero, ex[32]);
      chk1({tag, ".resp.err"}, (g == 0) ? rsp0_err : rsp1_err, ex[33]);
      chk32({tag, ".resp.otherdat"},
            (o == 0) ? {rsp0_result ^ {30'd0, rsp0_zero, rsp0_err}}
                     : {rsp1_result ^ {30'd0, rsp1_zero, rsp1_err}}, 32'd0);
      chk1({tag, ".resp.rdy0"}, req0_ready, 1'b0);
      chk1({tag, ".resp.rdy1"}, req1_ready, 1'b0);
    end

    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge clk);
    chk1({tag, ".done.busy"}, busy, 1'b0);
    chk1({tag, ".done.vld0"}, rsp0_valid, 1'b0);
    chk1({tag, ".done.vld1"}, rsp1_valid, 1'b0);
    chk32({tag, ".done.res0"}, rsp0_result, 32'd0);
    chk32({tag, ".done.res1"}, rsp1_result, 32'd0);
  endtask

  initial begin
    logic [3:0]  op_tab [10];
    logic [31:0] ra0, rb0, ra1, rb1;
    logic [3:0]  ro0, ro1;
    bit          rv0, rv1;

    op_tab = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100,
               4'b0011, 4'b0111, 4'b1010, 4'b0101, 4'b1111};

    reset = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    do_reset("reset");

    // Sole requester 0: 5 + 3.
    run_txn("add_solo", 1'b1, 1'b0, 32'd5, 32'd3, 4'b0010, 32'd0, 32'd0, 4'b0000, 0, 0, -1);

    // Fresh reset, then both requesters contending: literal order 0,1,0,1.
    do_reset("reset2");
    for (int i = 0; i < 4; i++) begin
      run_txn("rr", 1'b1, 1'b1, 32'd100 + 32'(i), 32'd7, 4'b0010,
              32'd200 + 32'(i), 32'd9, 4'b0110, 0, 0, i % 2);
    end

    // Requester 1 subtract to zero, consumer stalls 4 cycles while requester 0 waits.
    run_txn("sub_hold", 1'b0, 1'b1, 32'd0, 32'd0, 4'b0000,
            32'h1234, 32'h1234, 4'b0110, 4, 1, -1);

    // Unsupported op code.
    run_txn("bad_op", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1, 4'b1010, 32'd0, 32'd0, 4'b0000, 1, 0, -1);

    // Requester 0 shows valid for one cycle during requester 1's response, then withdraws.
    run_txn("withdraw", 1'b0, 1'b1, 32'd0, 32'd0, 4'b0000,
            32'h8000_0000, 32'h1, 4'b0111, 2, 2, -1);
    repeat (3) begin
      @(negedge clk);
      chk1("withdraw.idle.vld0", rsp0_valid, 1'b0);
      chk1("withdraw.idle.busy", busy, 1'b0);
    end

    // Reset while the op is in EXEC: dropped, no response, last-grant restored.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 32'hA5; req0_b = 32'h5A; req0_op = 4'b0010;
    @(negedge clk);
    chk1("rst_exec.rdy0", req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk1("rst_exec.busy_exec", busy, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk1("rst_exec.busy", busy, 1'b0);
    chk32("rst_exec.srca", alu_srca, 32'd0);
    chk32("rst_exec.aluop", {28'd0, alu_op}, 32'h2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("rst_exec.vld0", rsp0_valid, 1'b0);
      chk1("rst_exec.vld1", rsp1_valid, 1'b0);
    end
    m_last = (FIRST_PRIO == 0) ? 1 : 0;
    run_txn("tie_after_rst", 1'b1, 1'b1, 32'd1, 32'd2, 4'b0001,
            32'd3, 32'd4, 4'b0011, 0, 0, -1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      rv0 = 1'($urandom_range(0, 1));
      rv1 = rv0 ? 1'($urandom_range(0, 1)) : 1'b1;
      ra0 = $urandom;
      rb0 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
      ra1 = $urandom;
      rb1 = ($urandom_range(0, 3) == 0) ? ra1 : $urandom;
      ro0 = op_tab[$urandom_range(0, 9)];
      ro1 = op_tab[$urandom_range(0, 9)];
      run_txn("rnd", rv0, rv1, ra0, rb0, ro0, ra1, rb1, ro1,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter FIRST_PRIO, default 0, which selects the requester that wins the first simultaneous-request tie after reset.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-004 SHALL have ports: req0_valid/req1_valid  in  1  request present.
REQ-005 SHALL have ports: req0_a/req1_a, req0_b/req1_b  in  32  operands A and B.
REQ-006 SHALL have ports: req0_op/req1_op  in  4  ALU operation code.
REQ-007 SHALL have ports: req0_ready/req1_ready  out  1  request accepted this cycle.
REQ-008 SHALL have ports: rsp0_valid/rsp1_valid  out  1  response present.
REQ-009 SHALL have ports: rsp0_result/rsp1_result  out  32, rsp0_zero/rsp1_zero  out  1, rsp0_err/rsp1_err  out  1 (unsupported op).
REQ-010 SHALL have ports: rsp0_ready/rsp1_ready  in  1  response consumed.
REQ-011 SHALL have ports: alu_srca, alu_srcb  out  32, alu_op  out  4  drive the shared ALU.
REQ-012 SHALL have ports: alu_result  in  32, alu_zero  in  1  from the shared ALU (combinational).
REQ-013 SHALL have ports: busy  out  1  high in every state other than IDLE.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-015 SHALL, in IDLE, assert at most one reqN_ready: the only valid requester; if both are valid, the requester not granted last time (round-robin).
REQ-016 SHALL assert ready combinationally from valid in IDLE only, and deassert both readies in EXEC and RESP.
REQ-017 SHALL, on valid&&ready, capture a, b, op into operand registers, record the grant id, and move to EXEC.
REQ-018 SHALL drive alu_srca, alu_srcb, alu_op from the operand registers at all times.
REQ-019 SHALL accept op codes 0010 add, 0110 sub, 0000 and, 0001 or, 1100 nor, 0011 xor, 0111 slt; all other codes are unsupported.
REQ-020 SHALL, in EXEC, register alu_result and alu_zero into the result register for supported ops, or register result=0, zero=0, err=1 for unsupported ops, then move to RESP.
REQ-021 SHALL, in RESP, assert only rspG_valid for granted requester G; result, zero and err remain stable while valid && !ready.
REQ-022 SHALL, on rspG_valid && rspG_ready, return to IDLE; a new request may be accepted in the following cycle.
REQ-023 SHALL have a latency of accept at edge N, EXEC during cycle N+1, and rsp valid from cycle N+2; throughput is at most one op per 3 cycles.
REQ-024 SHALL ignore rsp ready of the non-granted requester and readiness while not in RESP.
REQ-025 SHALL capture nothing when valid drops before ready; this is legal.
REQ-026 SHALL update last-grant only on acceptance; a sole requester does not disturb fairness beyond its own grant.
REQ-027 SHALL force the rspN_* data outputs of a non-granted requester, and all rspN_* data outputs outside RESP, to 0.

Reset
REQ-028 SHALL, with reset high at a clock edge, set state=IDLE, operand regs a=0, b=0, op=0010, result=0, zero=0, err=0, all valid/ready outputs=0 (outside IDLE arbitration), busy=0, and last-grant such that FIRST_PRIO wins the next tie.
REQ-029 SHALL, on reset during EXEC or RESP, drop the in-flight op with no response issued.
REQ-030 SHALL give reset priority over every handshake in the same cycle.

Verification
REQ-031 SHALL cover: req0 a=5, b=3, op=0010 alone -> req0_ready same cycle; rsp0_valid 2 cycles later, result=8, zero=0.
REQ-032 SHALL cover: both requesters valid every cycle after reset with FIRST_PRIO=0 -> grants 0,1,0,1 in order; no requester starved.
REQ-033 SHALL cover: req1 a=b=0x1234, op=0110, with rsp1_ready held low 4 cycles -> result=0, zero=1, held stable; no new accept until the response handshake.
REQ-034 SHALL cover: req0 op=1010 -> rsp0 result=0, zero=0, err=1.
REQ-035 SHALL cover: reset asserted in EXEC -> next cycle IDLE, busy=0, no rsp valid ever for that op.
REQ-036 SHALL cover: req0 valid for 1 cycle while in RESP, then withdrawn -> never captured, no extra response.
